// File: rtl/term_sm_pkg.sv
// Shared types and elaboration-time helpers for the configurable terminal-tile
// switch matrix.
//   - cfg_state_e : loader FSM states
//   - clog2       : ceiling log2 usable in constant expressions
//   - sel_width   : per-channel select field width (never below 1)
//   - cfg_bits    : total configuration chain length
//   - field_off   : bit offset of channel ch's {reg_en, sel} field
package term_sm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } cfg_state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int sel_width(input int num_src);
        return (clog2(num_src) < 1) ? 1 : clog2(num_src);
    endfunction

    function automatic int cfg_bits(input int num_ch, input int num_src);
        return num_ch * (sel_width(num_src) + 1);
    endfunction

    // Each channel owns SEL_W select bits followed by one reg_en bit.
    function automatic int field_off(input int ch, input int sel_w);
        return ch * (sel_w + 1);
    endfunction

endpackage

// File: rtl/term_sm_cfg_loader.sv
// Serial configuration loader for the terminal-tile switch matrix.
// Bits are shifted into a shadow register, the load length is counted, and a
// commit copies shadow to active only when exactly CFG_BITS bits were shifted.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   cfg_en_i        shift cfg_din_i into the shadow this cycle
//   cfg_din_i       serial configuration data
//   cfg_commit_i    request to commit shadow to active
//   cfg_dout_o      serial chain output (shadow bit 0)
//   cfg_busy_o      high while in SHIFT
//   cfg_done_o      one-cycle pulse after a successful commit
//   cfg_err_o       sticky length/protocol error, cleared by a good commit
//   active_o        committed routing vector
module term_sm_cfg_loader
    import term_sm_pkg::*;
#(
    parameter int NUM_CH  = 20,
    parameter int NUM_SRC = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                cfg_en_i,
    input  logic                                cfg_din_i,
    input  logic                                cfg_commit_i,
    output logic                                cfg_dout_o,
    output logic                                cfg_busy_o,
    output logic                                cfg_done_o,
    output logic                                cfg_err_o,
    output logic [cfg_bits(NUM_CH, NUM_SRC)-1:0] active_o
);

    localparam int CFG_BITS = cfg_bits(NUM_CH, NUM_SRC);
    // Counter must hold CFG_BITS+1, the saturating overflow marker.
    localparam int CNT_W    = clog2(CFG_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(CFG_BITS + 1);

    cfg_state_e          state_q,  state_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                err_q,    err_d;

    logic [CFG_BITS-1:0] shadow_shifted;
    assign shadow_shifted = {cfg_din_i, shadow_q[CFG_BITS-1:1]};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (cfg_en_i && cfg_commit_i) begin
                    err_d = 1'b1;
                end else if (cfg_en_i) begin
                    shadow_d = shadow_shifted;
                    cnt_d    = CNT_W'(1);
                    state_d  = ST_SHIFT;
                end else if (cfg_commit_i) begin
                    err_d = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (cfg_en_i && cfg_commit_i) begin
                    // Ambiguous request: neither shift nor commit happens.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cfg_en_i) begin
                    shadow_d = shadow_shifted;
                    if (cnt_q != CNT_OVF) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cfg_commit_i) begin
                    cnt_d = '0;
                    if (cnt_q == CNT_FULL) begin
                        active_d = shadow_q;
                        err_d    = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the configuration registers are reset, not left undefined, so
    // the outputs come up as a clean source-0 pass-through.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign cfg_dout_o = shadow_q[0];
    assign cfg_busy_o = (state_q == ST_SHIFT);
    assign cfg_done_o = (state_q == ST_DONE);
    assign cfg_err_o  = err_q;
    assign active_o   = active_q;

endmodule

// File: rtl/term_switch_matrix_cfg.sv
// Configurable terminal-tile switch matrix. Each of NUM_CH outputs selects one
// of NUM_SRC source buses, optionally through a one-cycle register stage.
// Routing is loaded through the serial loader and committed atomically.
// Ports:
//   UserCLK     fabric user clock, all state on the rising edge
//   resetn      asynchronous active-low reset
//   src_bus     sources; source k of channel i is bit k*NUM_CH+i
//   out_bus     routed outputs
//   cfg_en      shift enable
//   cfg_din     serial configuration data
//   cfg_commit  commit request
//   cfg_dout    serial chain output
//   cfg_busy    high while shifting
//   cfg_done    one-cycle pulse after a successful commit
//   cfg_err     sticky length/protocol error
module term_switch_matrix_cfg
    import term_sm_pkg::*;
#(
    parameter int NUM_CH  = 20,
    parameter int NUM_SRC = 4
) (
    input  logic                       UserCLK,
    input  logic                       resetn,
    input  logic [NUM_SRC*NUM_CH-1:0]  src_bus,
    output logic [NUM_CH-1:0]          out_bus,
    input  logic                       cfg_en,
    input  logic                       cfg_din,
    input  logic                       cfg_commit,
    output logic                       cfg_dout,
    output logic                       cfg_busy,
    output logic                       cfg_done,
    output logic                       cfg_err
);

    localparam int SEL_W    = sel_width(NUM_SRC);
    localparam int CFG_BITS = cfg_bits(NUM_CH, NUM_SRC);

    logic [CFG_BITS-1:0] active;

    term_sm_cfg_loader #(
        .NUM_CH  (NUM_CH),
        .NUM_SRC (NUM_SRC)
    ) u_loader (
        .clk_i        (UserCLK),
        .rst_ni       (resetn),
        .cfg_en_i     (cfg_en),
        .cfg_din_i    (cfg_din),
        .cfg_commit_i (cfg_commit),
        .cfg_dout_o   (cfg_dout),
        .cfg_busy_o   (cfg_busy),
        .cfg_done_o   (cfg_done),
        .cfg_err_o    (cfg_err),
        .active_o     (active)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int OFF = field_off(i, SEL_W);

        logic [SEL_W-1:0]   sel;
        logic               reg_en;
        logic [NUM_SRC-1:0] src_vec;
        logic               mux;
        logic               q_q;

        assign sel    = active[OFF +: SEL_W];
        assign reg_en = active[OFF + SEL_W];

        for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
            assign src_vec[k] = src_bus[k*NUM_CH + i];
        end

        // Out-of-range selects (non-power-of-two NUM_SRC) fall back to source 0.
        always_comb begin
            mux = src_vec[0];
            if (int'(sel) < NUM_SRC) begin
                mux = src_vec[sel];
            end
        end

        // The stage runs every cycle so a switch into registered mode shows
        // already-sampled data rather than stale reset contents.
        always_ff @(posedge UserCLK or negedge resetn) begin
            if (!resetn) begin
                q_q <= 1'b0;
            end else begin
                q_q <= mux;
            end
        end

        assign out_bus[i] = reg_en ? q_q : mux;
    end

endmodule

// File: tb/tb_term_switch_matrix_cfg.sv
module tb_term_switch_matrix_cfg;

    logic        UserCLK = 1'b0;
    logic        resetn;
    logic [79:0] src_bus;
    logic [19:0] out_bus;
    logic        cfg_en;
    logic        cfg_din;
    logic        cfg_commit;
    logic        cfg_dout;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 UserCLK = ~UserCLK;

    term_switch_matrix_cfg #(
        .NUM_CH  (20),
        .NUM_SRC (4)
    ) dut (
        .UserCLK    (UserCLK),
        .resetn     (resetn),
        .src_bus    (src_bus),
        .out_bus    (out_bus),
        .cfg_en     (cfg_en),
        .cfg_din    (cfg_din),
        .cfg_commit (cfg_commit),
        .cfg_dout   (cfg_dout),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    // Every channel gets the same {reg_en, sel} field.
    function automatic logic [59:0] mk_word(input logic [1:0] sel, input logic reg_en);
        logic [59:0] w;
        for (int c = 0; c < 20; c++) begin
            w[c*3 +: 2] = sel;
            w[c*3 + 2]  = reg_en;
        end
        return w;
    endfunction

    // Shifted LSB first: word bit 0 ends in shadow bit 0 after 60 shifts.
    task automatic shift_bits(input logic [59:0] w, input int n);
        for (int j = 0; j < n; j++) begin
            cfg_en  = 1'b1;
            cfg_din = w[j % 60];
            tick();
        end
        cfg_en  = 1'b0;
        cfg_din = 1'b0;
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    logic [59:0] w;

    initial begin
        resetn     = 1'b0;
        cfg_en     = 1'b0;
        cfg_din    = 1'b0;
        cfg_commit = 1'b0;
        src_bus    = '0;
        src_bus[19:0] = 20'hA5A5A;
        #1;
        check("rst_out", out_bus, 20'hA5A5A);
        check("rst_busy", cfg_busy, 1'b0);
        check("rst_done", cfg_done, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        check("rst_dout", cfg_dout, 1'b0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Full load, all channels sel=2 combinational
        src_bus = {20'h00000, 20'h12345, 20'hFFFFF, 20'h00000};
        shift_bits(mk_word(2'd2, 1'b0), 60);
        check("load_busy", cfg_busy, 1'b1);
        check("load_out_before", out_bus, 20'h00000);
        do_commit();
        check("commit_done", cfg_done, 1'b1);
        check("commit_err", cfg_err, 1'b0);
        check("commit_busy", cfg_busy, 1'b0);
        check("commit_out", out_bus, 20'h12345);
        tick();
        check("done_pulse_end", cfg_done, 1'b0);

        // Register mode on channel 0 from source 1, rest source 0
        w = mk_word(2'd0, 1'b0);
        w[2:0] = 3'b101;
        shift_bits(w, 60);
        do_commit();
        src_bus[19:0] = 20'h5A5A5;
        src_bus[20]   = 1'b0;
        tick();
        check("reg_settle", out_bus, 20'h5A5A4);
        src_bus[19:0] = 20'hA5A5A;
        src_bus[20]   = 1'b1;
        #1;
        check("reg_comb_rest", out_bus, 20'hA5A5A);
        tick();
        check("reg_rise", out_bus, 20'hA5A5B);
        src_bus[20] = 1'b0;
        #1;
        check("reg_hold", out_bus, 20'hA5A5B);
        tick();
        check("reg_fall", out_bus, 20'hA5A5A);

        // Short load
        shift_bits(mk_word(2'd2, 1'b0), 59);
        do_commit();
        check("short_err", cfg_err, 1'b1);
        check("short_done", cfg_done, 1'b0);
        check("short_busy", cfg_busy, 1'b0);
        check("short_out", out_bus, 20'hA5A5A);

        // Overlong load
        shift_bits(mk_word(2'd2, 1'b0), 61);
        check("long_err_sticky", cfg_err, 1'b1);
        do_commit();
        check("long_err", cfg_err, 1'b1);
        check("long_done", cfg_done, 1'b0);
        check("long_out", out_bus, 20'hA5A5A);

        // Correct load clears the error
        shift_bits(mk_word(2'd2, 1'b0), 60);
        do_commit();
        check("recover_err", cfg_err, 1'b0);
        check("recover_done", cfg_done, 1'b1);
        check("recover_out", out_bus, 20'h12345);
        tick();

        // Simultaneous shift and commit at bit 60
        shift_bits(mk_word(2'd1, 1'b0), 60);
        check("sim_pre_dout", cfg_dout, 1'b1);
        cfg_en     = 1'b1;
        cfg_commit = 1'b1;
        cfg_din    = 1'b0;
        tick();
        cfg_en     = 1'b0;
        cfg_commit = 1'b0;
        check("sim_err", cfg_err, 1'b1);
        check("sim_busy", cfg_busy, 1'b0);
        check("sim_done", cfg_done, 1'b0);
        check("sim_noshift", cfg_dout, 1'b1);
        check("sim_out", out_bus, 20'h12345);

        // Commit in IDLE after a clean load
        shift_bits(mk_word(2'd2, 1'b0), 60);
        do_commit();
        check("clean_err", cfg_err, 1'b0);
        tick();
        do_commit();
        check("idle_commit_err", cfg_err, 1'b1);
        check("idle_commit_done", cfg_done, 1'b0);
        check("idle_commit_out", out_bus, 20'h12345);

        // Reset mid-shift
        shift_bits(mk_word(2'd3, 1'b0), 30);
        check("mid_busy", cfg_busy, 1'b1);
        resetn = 1'b0;
        #1;
        check("mid_rst_busy", cfg_busy, 1'b0);
        check("mid_rst_err", cfg_err, 1'b0);
        check("mid_rst_out", out_bus, 20'hA5A5A);
        check("mid_rst_dout", cfg_dout, 1'b0);
        tick();
        resetn = 1'b1;
        tick();
        src_bus[79:60] = 20'hBEEF1;
        w = mk_word(2'd3, 1'b0);
        shift_bits(w, 1);
        check("post_rst_first_dout", cfg_dout, 1'b0);
        shift_bits({w[0], w[59:1]}, 59);
        check("replay_dout", cfg_dout, 1'b1);
        do_commit();
        check("sel3_done", cfg_done, 1'b1);
        check("sel3_err", cfg_err, 1'b0);
        check("sel3_out", out_bus, 20'hBEEF1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
